// File: rtl/masked_pkg.sv
// Shared definitions for the masked neuron datapath (dot-product front end,
// sign/ReLU stages). Keeps the default word width and FSM state encoding in
// one place so that every stage decodes the debug state the same way.
package masked_pkg;

  // Default datapath width; all masked arithmetic is mod 2^W.
  localparam int W_DEFAULT = 64;

  // Control states shared by the masked stages.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/masked_mac_unit.sv
// Combinational multiply-accumulate step for one masked element.
// Unmasks the activation, forms the low half of the product with the weight
// and adds it to the running accumulator. It is kept separate so that it can
// later be pipelined or replaced by a garbling-friendly multiplier.
module masked_mac_unit #(
  parameter int W = masked_pkg::W_DEFAULT
) (
  input  logic [W-1:0] e_input,
  input  logic [W-1:0] g_mask,
  input  logic [W-1:0] g_weight,
  input  logic [W-1:0] acc,
  output logic [W-1:0] prod,
  output logic [W-1:0] acc_next
);

  logic [W-1:0] x_plain;

  // Unmask, multiply and accumulate. The low half of the product is the
  // same for signed and unsigned operands, so a two's complement weight
  // needs no special handling.
  always_comb begin
    x_plain  = e_input + g_mask;
    prod     = x_plain * g_weight;
    acc_next = acc + prod;
  end

endmodule

// File: rtl/masked_dot_accum.sv
// Sequential masked dot product: o = (bias + sum x_i*w_i) - out_mask, mod 2^W.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; a producer holds its data stable while valid is high and ready
// is low, and ready never depends combinationally on valid.
// in_valid/in_ready carry element beats; out_valid/out_ready carry o.
module masked_dot_accum
  import masked_pkg::*;
#(
  parameter int N_ELEM = 16,
  parameter int W      = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] g_bias,
  input  logic [W-1:0] g_out_mask,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] e_input,
  input  logic [W-1:0] g_mask,
  input  logic [W-1:0] g_weight,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] o,
  output logic         busy,
  output logic [1:0]   state_dbg
);

  localparam int                CNT_W    = $clog2(N_ELEM + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ELEM - 1);

  state_t           state;
  logic [W-1:0]     acc;
  logic [W-1:0]     out_mask_q;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     prod;
  logic [W-1:0]     acc_next;

  masked_mac_unit #(.W(W)) u_mac (
    .e_input  (e_input),
    .g_mask   (g_mask),
    .g_weight (g_weight),
    .acc      (acc),
    .prod     (prod),
    .acc_next (acc_next)
  );

  // State is exported raw so checkers can follow the control flow.
  always_comb state_dbg = state;

  // Control FSM with registered handshake outputs; a reset at any point
  // clears the accumulator and counter so an aborted op leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      out_mask_q <= '0;
      cnt        <= '0;
      o          <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc        <= g_bias;
            out_mask_q <= g_out_mask;
            cnt        <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            state      <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid && in_ready) begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_IDX) begin
              // Final beat: fold in the last product and apply the output mask.
              o         <= acc_next - out_mask_q;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          // start in this state (including the handshake cycle) is dropped.
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
